// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: two-requester round-robin arbiter for a single register-file
// write port. Requester 0 is ALU writeback, requester 1 is load writeback.
// The accepted write is presented to the register file one cycle after the
// handshake. Writes aimed at the zero register are accepted but suppressed,
// and a saturating counter records them.
module rf_write_arbiter #(
  parameter int DW       = 64,
  parameter int AW       = 5,
  parameter int ZR_INDEX = 31
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_rd,
  input  logic [DW-1:0] req0_d,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_rd,
  input  logic [DW-1:0] req1_d,
  output logic          req1_ready,
  output logic          rf_wr,
  output logic [AW-1:0] rf_rd,
  output logic [DW-1:0] rf_d,
  output logic          last_grant,
  output logic [7:0]    drop_count
);

  localparam logic [AW-1:0] ZR_IDX = AW'(ZR_INDEX);

  // Saturating increment for the 8-bit drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'd255) begin
      return 8'd255;
    end else begin
      return v + 8'd1;
    end
  endfunction

  logic          gnt0_s;
  logic          gnt1_s;
  logic [AW-1:0] sel_rd_s;
  logic [DW-1:0] sel_d_s;

  logic          rf_wr_q,      rf_wr_d;
  logic [AW-1:0] rf_rd_q,      rf_rd_d;
  logic [DW-1:0] rf_d_q,       rf_d_d;
  logic          last_grant_q, last_grant_d;
  logic [7:0]    drop_count_q, drop_count_d;

  // Grant decision: single valid wins; on contention the requester not granted last wins.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case ({req1_valid, req0_valid})
        2'b01: gnt0_s = 1'b1;
        2'b10: gnt1_s = 1'b1;
        2'b11: begin
          if (last_grant_q) begin
            gnt0_s = 1'b1;
          end else begin
            gnt1_s = 1'b1;
          end
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;

  // Select the winning requester's destination and data.
  always_comb begin
    sel_rd_s = req0_rd;
    sel_d_s  = req0_d;
    if (gnt1_s) begin
      sel_rd_s = req1_rd;
      sel_d_s  = req1_d;
    end else begin
      sel_rd_s = req0_rd;
      sel_d_s  = req0_d;
    end
  end

  // Next-state for the write slot, grant history and drop counter.
  // A zero-register write leaves rf_rd/rf_d at their previous values.
  always_comb begin
    rf_wr_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_d_d       = rf_d_q;
    last_grant_d = last_grant_q;
    drop_count_d = drop_count_q;
    if (gnt0_s || gnt1_s) begin
      last_grant_d = gnt1_s;
      if (sel_rd_s == ZR_IDX) begin
        rf_wr_d      = 1'b0;
        drop_count_d = sat_inc8(drop_count_q);
      end else begin
        rf_wr_d = 1'b1;
        rf_rd_d = sel_rd_s;
        rf_d_d  = sel_d_s;
      end
    end else begin
      rf_wr_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wr_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_d_q       <= '0;
      last_grant_q <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      rf_wr_q      <= rf_wr_d;
      rf_rd_q      <= rf_rd_d;
      rf_d_q       <= rf_d_d;
      last_grant_q <= last_grant_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign rf_wr      = rf_wr_q;
  assign rf_rd      = rf_rd_q;
  assign rf_d       = rf_d_q;
  assign last_grant = last_grant_q;
  assign drop_count = drop_count_q;

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
- REQ-001 Parameter: DW, 64, write-data width in bits.
- REQ-002 Parameter: AW, 5, register-index width in bits.
- REQ-003 Parameter: ZR_INDEX, 31, zero-register index; writes to it are discarded.
- REQ-004 Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- REQ-005 Port: clk  input  1  system clock; all state updates on the rising edge.
- REQ-006 Port: reset  input  1  synchronous active-high reset.
- REQ-007 Port: req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
- REQ-008 Port: req0_rd  input  AW  requester 0 destination register.
- REQ-009 Port: req0_d  input  DW  requester 0 write data.
- REQ-010 Port: req0_ready  output  1  requester 0 transfer accepted this cycle.
- REQ-011 Port: req1_valid / req1_rd / req1_d / req1_ready, same directions and widths as requester 0, for requester 1 (load writeback).
- REQ-012 Port: rf_wr  output  1  register-file write enable.
- REQ-013 Port: rf_rd  output  AW  register-file destination index.
- REQ-014 Port: rf_d  output  DW  register-file write data.
- REQ-015 Port: last_grant  output  1  index of the most recently granted requester.
- REQ-016 Port: drop_count  output  8  number of accepted writes discarded because they targeted ZR_INDEX.

Function
- REQ-017 Handshake: a transfer on requester i occurs in a cycle where reqi_valid and reqi_ready are both 1; a requester SHALL hold valid, rd and d stable until that transfer.
- REQ-018 reqi_ready is combinational from the valids and last_grant; at most one ready is 1 per cycle; ready is never 1 when the matching valid is 0.
- REQ-019 Only requester i valid: grant i.
- REQ-020 Both valid: grant the requester not equal to last_grant (round-robin).
- REQ-021 Neither valid: no grant; last_grant holds.
- REQ-022 On a grant, last_grant updates to the granted index at the next edge.
- REQ-023 Latency: a transfer accepted at edge N drives rf_wr, rf_rd and rf_d from registers for the cycle following edge N; the register file captures it at edge N+1.
- REQ-024 When the accepted rd equals ZR_INDEX, rf_wr SHALL be 0 for that slot and drop_count SHALL increment by 1.
- REQ-025 A discarded write is still a completed transfer (ready = 1) and still updates last_grant.
- REQ-026 drop_count saturates at 255.
- REQ-027 With no transfer in a cycle, rf_wr is 0 in the next cycle; rf_rd and rf_d hold their last values.
- REQ-028 Both requesters targeting the same rd: serialise one per cycle in round-robin order; the later write lands last.
- REQ-029 Starvation bound: a continuously valid requester is granted within 2 cycles of raising valid.

Reset
- REQ-030 While reset = 1 at an edge, rf_wr, last_grant and drop_count are cleared to 0 and rf_rd and rf_d are cleared to 0.
- REQ-031 While reset = 1, both readies SHALL be 0 and no transfer occurs.
- REQ-032 A transfer presented in the reset cycle is not accepted; the requester keeps valid asserted.
- REQ-033 A write already registered before reset is dropped, so rf_wr is 0 after the reset edge.
- REQ-034 After reset, requester 1 has priority on the first contention, because last_grant = 0.

Verification
- REQ-035 Single write: req0 valid, rd = 3, d = 0x1234 for one cycle -> req0_ready = 1 that cycle; next cycle rf_wr = 1, rf_rd = 3, rf_d = 0x1234.
- REQ-036 Contention after reset: both valid continuously, rd0 = 1, rd1 = 2 -> grants alternate 1, 0, 1, 0; rf_rd sequence 2, 1, 2, 1; rf_wr is 1 every cycle.
- REQ-037 Zero register: req1 writes rd = 31 -> req1_ready = 1, next-cycle rf_wr = 0, drop_count 0 -> 1; 300 such writes -> drop_count = 255.
- REQ-038 Same destination: both write rd = 5, d0 = 0xA, d1 = 0xB, with last_grant = 1 -> rf_d = 0xA, then 0xB.
- REQ-039 Reset mid-stream: reset asserted while rf_wr = 1 and both valid -> both readies 0; after the reset edge, rf_wr = 0, drop_count = 0, last_grant = 0; the first grant after reset deasserts goes to requester 1.
- REQ-040 Idle: both valids 0 for 10 cycles -> rf_wr = 0, rf_rd and rf_d unchanged, last_grant unchanged.
